// File: rtl/bpf_cal_seq_if.sv
// Control/status bundle between the radio control FSM and the BPF power-up/calibration sequencer.
interface bpf_cal_seq_if;
  logic       start;
  logic       stop;
  logic       rdy_bpf;
  logic       pu_bpf;
  logic       cal_bpf;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state;
  logic [2:0] retry_cnt;

  modport master (
    output start, stop, rdy_bpf,
    input  pu_bpf, cal_bpf, busy, done, err, state, retry_cnt
  );

  modport slave (
    input  start, stop, rdy_bpf,
    output pu_bpf, cal_bpf, busy, done, err, state, retry_cnt
  );
endinterface

// File: rtl/bpf_cal_seq.sv
// BPF power-up / calibration sequencer with ready timeout and bounded retries.
// Optional macro PERIODIC_RECAL_EN adds periodic recalibration from READY with stale-ready rejection.
module bpf_cal_seq #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 2048,
  parameter int unsigned OFF_CYC     = 4,
  parameter int unsigned MAX_RETRY   = 2
`ifdef PERIODIC_RECAL_EN
  , parameter int unsigned RECAL_CYC = 50000
`endif
) (
  input logic          clk,
  input logic          rst,
  bpf_cal_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CAL    = 3'd2,
    S_OFF    = 3'd3,
    S_READY  = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] OFF_LAST     = 16'(OFF_CYC - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRY);
`ifdef PERIODIC_RECAL_EN
  localparam logic [15:0] RECAL_LAST   = 16'(RECAL_CYC - 1);
`endif

  state_t      state_r;
  state_t      state_nxt;
  logic [15:0] cnt_r;
  logic [2:0]  retry_r;
  logic [2:0]  retry_nxt;
  logic [4:0]  outs_r;
  logic        rdy_ok;
  logic        timed;

  // Output bits {pu, cal, busy, done, err} for each state
  function automatic logic [4:0] decode(input state_t s);
    logic [4:0] o;
    case (s)
      S_SETTLE: o = 5'b10100;
      S_CAL:    o = 5'b11100;
      S_OFF:    o = 5'b00100;
      S_READY:  o = 5'b10010;
      S_FAIL:   o = 5'b00001;
      default:  o = 5'b00000;
    endcase
    return o;
  endfunction

`ifdef PERIODIC_RECAL_EN
  logic seen_low_r;

  // A ready level left over from READY must go low once before it counts
  assign rdy_ok = bus.rdy_bpf & seen_low_r;
  assign timed  = (state_r == S_SETTLE) || (state_r == S_CAL) ||
                  (state_r == S_OFF)    || (state_r == S_READY);
`else
  assign rdy_ok = bus.rdy_bpf;
  assign timed  = (state_r == S_SETTLE) || (state_r == S_CAL) || (state_r == S_OFF);
`endif

  // Next-state and retry bookkeeping; STOP overrides everything
  always_comb begin
    state_nxt = state_r;
    retry_nxt = retry_r;
    if (bus.stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_FAIL: begin
          if (bus.start) begin
            state_nxt = S_SETTLE;
            retry_nxt = 3'd0;
          end else begin
            state_nxt = state_r;
          end
        end
        S_SETTLE: begin
          if (cnt_r == SETTLE_LAST) state_nxt = S_CAL;
          else                      state_nxt = S_SETTLE;
        end
        S_CAL: begin
          if (rdy_ok) begin
            state_nxt = S_READY;
          end else if (cnt_r == TIMEOUT_LAST) begin
            if (retry_r < RETRY_MAX) begin
              state_nxt = S_OFF;
              retry_nxt = retry_r + 3'd1;
            end else begin
              state_nxt = S_FAIL;
            end
          end else begin
            state_nxt = S_CAL;
          end
        end
        S_OFF: begin
          if (cnt_r == OFF_LAST) state_nxt = S_SETTLE;
          else                   state_nxt = S_OFF;
        end
        S_READY: begin
          if (!bus.rdy_bpf) begin
            state_nxt = S_FAIL;
`ifdef PERIODIC_RECAL_EN
          end else if (cnt_r == RECAL_LAST) begin
            state_nxt = S_CAL;
            retry_nxt = 3'd0;
`endif
          end else begin
            state_nxt = S_READY;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counter, retry and registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 16'd0;
      retry_r    <= 3'd0;
      outs_r     <= 5'b00000;
`ifdef PERIODIC_RECAL_EN
      seen_low_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      retry_r <= retry_nxt;
      outs_r  <= decode(state_nxt);
      if ((state_nxt != state_r) || !timed) cnt_r <= 16'd0;
      else                                  cnt_r <= cnt_r + 16'd1;
`ifdef PERIODIC_RECAL_EN
      if ((state_nxt == S_CAL) && (state_r != S_CAL))  seen_low_r <= 1'b0;
      else if ((state_r == S_CAL) && !bus.rdy_bpf)     seen_low_r <= 1'b1;
      else                                             seen_low_r <= seen_low_r;
`endif
    end
  end

  assign {bus.pu_bpf, bus.cal_bpf, bus.busy, bus.done, bus.err} = outs_r;
  assign bus.state     = state_r;
  assign bus.retry_cnt = retry_r;

endmodule

// File: tb/tb_bpf_cal_seq.sv
// Self-checking bench for bpf_cal_seq: scoreboarded expectations keyed by cycle number.
module tb_bpf_cal_seq;
  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int OFFC   = 4;
  localparam int MAXR   = 2;
  localparam int RECAL  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bpf_cal_seq_if bus();

  bpf_cal_seq #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO),
    .OFF_CYC    (OFFC),
    .MAX_RETRY  (MAXR)
`ifdef PERIODIC_RECAL_EN
    , .RECAL_CYC(RECAL)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [10:0] val;
    string      name;
  } exp_t;

  typedef struct {
    string      name;
    int         rise;
    int         fin;
    logic [2:0] fst;
    logic [2:0] frt;
    bit         detail;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Expected {state, pu, cal, busy, done, err, retry} straight from the state table
  function automatic logic [10:0] pack(input logic [2:0] st, input logic [2:0] rc);
    logic [4:0] o;
    case (st)
      3'd1:    o = 5'b10100;
      3'd2:    o = 5'b11100;
      3'd3:    o = 5'b00100;
      3'd4:    o = 5'b10010;
      3'd5:    o = 5'b00001;
      default: o = 5'b00000;
    endcase
    return {st, o, rc};
  endfunction

  task automatic expect_at(input int c, input logic [2:0] st, input logic [2:0] rc, input string nm);
    exp_t e;
    int   i;
    e = '{c, pack(st, rc), nm};
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    logic [10:0] act;
    act = {bus.state, bus.pu_bpf, bus.cal_bpf, bus.busy, bus.done, bus.err, bus.retry_cnt};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checks++;
      if (sb[0].cyc < cyc || act !== sb[0].val) begin
        errors++;
        $display("FAIL %s at cyc %0d (due %0d): got st/pu/cal/busy/done/err/rc=%b want %b",
                 sb[0].name, cyc, sb[0].cyc, act, sb[0].val);
      end
      void'(sb.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      tick(1);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.rdy_bpf = 1'b0;
    tick(3);
    rst = 1'b0;
    expect_at(cyc, 3'd0, 3'd0, "reset");
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   s;
    int   c;
    int   f;
    int   cr;

    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.rdy_bpf = 1'b0;

    // rise: cycle offset from CAL entry when RDY is driven high (-1 never); fin: offset of final state
    vt[0] = '{"rdy40",    40,  41,  3'd4, 3'd0, 1'b0};
    vt[1] = '{"rdy_edge", 63,  64,  3'd4, 3'd0, 1'b0};
    vt[2] = '{"never",    -1,  232, 3'd5, 3'd2, 1'b1};
    vt[3] = '{"rdy_2nd",  94,  95,  3'd4, 3'd1, 1'b0};
`ifdef PERIODIC_RECAL_EN
    vt[4] = '{"rdy_late", 64,  232, 3'd5, 3'd2, 1'b0};
`else
    vt[4] = '{"rdy_late", 64,  85,  3'd4, 3'd1, 1'b0};
`endif
    vt[5] = '{"rdy_3rd",  231, 232, 3'd4, 3'd2, 1'b0};

    foreach (vt[i]) begin
      do_reset();
      s = cyc;
      c = s + 1 + SETTLE;
      f = c + vt[i].fin;
      expect_at(s + 1, 3'd1, 3'd0, {vt[i].name, "_settle"});
      expect_at(c - 1, 3'd1, 3'd0, {vt[i].name, "_settle_end"});
      expect_at(c,     3'd2, 3'd0, {vt[i].name, "_cal"});
      expect_at(f - 1, 3'd2, vt[i].frt, {vt[i].name, "_pre"});
      expect_at(f,     vt[i].fst, vt[i].frt, {vt[i].name, "_fin"});
      expect_at(f + 2, vt[i].fst, vt[i].frt, {vt[i].name, "_hold"});
      if (vt[i].detail) begin
        expect_at(c + 63,  3'd2, 3'd0, "cal1_last");
        expect_at(c + 64,  3'd3, 3'd1, "off1");
        expect_at(c + 67,  3'd3, 3'd1, "off1_last");
        expect_at(c + 68,  3'd1, 3'd1, "settle2");
        expect_at(c + 84,  3'd2, 3'd1, "cal2");
        expect_at(c + 168, 3'd2, 3'd2, "cal3");
      end
      pulse_start();
      if (vt[i].rise >= 0) begin
        wait_until(c + vt[i].rise);
        bus.rdy_bpf = 1'b1;
      end
      wait_until(f + 3);
      drain();
    end

    // STOP mid-SETTLE, mid-CAL and in READY together with START
    do_reset();
    s = cyc;
    expect_at(s + 6,  3'd0, 3'd0, "stop_settle");
    expect_at(s + 10, 3'd0, 3'd0, "stop_settle_hold");
    pulse_start();
    wait_until(s + 5);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    wait_until(s + 12);
    s = cyc;
    c = s + 1 + SETTLE;
    expect_at(c,      3'd2, 3'd0, "cal_b");
    expect_at(c + 11, 3'd0, 3'd0, "stop_cal");
    expect_at(c + 15, 3'd0, 3'd0, "stop_cal_hold");
    pulse_start();
    wait_until(c + 10);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    wait_until(c + 16);
    s = cyc;
    c = s + 1 + SETTLE;
    expect_at(c + 6,  3'd4, 3'd0, "ready_c");
    expect_at(c + 11, 3'd0, 3'd0, "stop_ready");
    expect_at(c + 13, 3'd0, 3'd0, "startstop_idle");
    expect_at(c + 17, 3'd0, 3'd0, "idle_rdy_ignored");
    expect_at(c + 20, 3'd1, 3'd0, "restart");
    pulse_start();
    wait_until(c + 5);
    bus.rdy_bpf = 1'b1;
    wait_until(c + 10);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    wait_until(c + 13);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    wait_until(c + 19);
    bus.start = 1'b1;
    tick(1);
    bus.start   = 1'b0;
    bus.rdy_bpf = 1'b0;
    wait_until(c + 22);
    drain();

    // Lost lock in READY, then restart from FAIL
    do_reset();
    s = cyc;
    c = s + 1 + SETTLE;
    expect_at(c + 6,  3'd4, 3'd0, "lock_ready");
    expect_at(c + 11, 3'd5, 3'd0, "lock_lost");
    expect_at(c + 14, 3'd5, 3'd0, "fail_hold");
    expect_at(c + 16, 3'd1, 3'd0, "fail_restart");
    pulse_start();
    wait_until(c + 5);
    bus.rdy_bpf = 1'b1;
    wait_until(c + 10);
    bus.rdy_bpf = 1'b0;
    wait_until(c + 15);
    pulse_start();
    wait_until(c + 18);
    drain();

    // Exhausted retries, START clears RETRY_CNT, then RST mid-CAL
    do_reset();
    s = cyc;
    c = s + 1 + SETTLE;
    cr = c + 236 + SETTLE;
    expect_at(c + 232, 3'd5, 3'd2, "exhausted");
    expect_at(c + 236, 3'd1, 3'd0, "start_clears_retry");
    expect_at(cr,      3'd2, 3'd0, "cal_again");
    expect_at(cr + 4,  3'd0, 3'd0, "rst_mid_cal");
    pulse_start();
    wait_until(c + 235);
    pulse_start();
    wait_until(cr + 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_until(cr + 6);
    drain();

`ifdef PERIODIC_RECAL_EN
    // RDY held high across recalibration: stale ready rejected, sequence times out
    do_reset();
    s  = cyc;
    c  = s + 1 + SETTLE;
    f  = c + 41;
    cr = f + RECAL;
    expect_at(f,        3'd4, 3'd0, "recal_ready");
    expect_at(cr - 1,   3'd4, 3'd0, "recal_ready_end");
    expect_at(cr,       3'd2, 3'd0, "recal_cal");
    expect_at(cr + 64,  3'd3, 3'd1, "stale_timeout");
    expect_at(cr + 232, 3'd5, 3'd2, "stale_fail");
    pulse_start();
    wait_until(c + 40);
    bus.rdy_bpf = 1'b1;
    wait_until(cr + 234);
    drain();

    // RDY pulsed low then high during recal: READY returns, RETRY_CNT cleared
    do_reset();
    s  = cyc;
    c  = s + 1 + SETTLE;
    f  = c + 95;
    cr = f + RECAL;
    expect_at(f,      3'd4, 3'd1, "recal2_ready");
    expect_at(cr,     3'd2, 3'd0, "recal2_cal");
    expect_at(cr + 5, 3'd2, 3'd0, "recal2_wait");
    expect_at(cr + 6, 3'd4, 3'd0, "recal2_back");
    pulse_start();
    wait_until(c + 94);
    bus.rdy_bpf = 1'b1;
    wait_until(cr + 2);
    bus.rdy_bpf = 1'b0;
    wait_until(cr + 5);
    bus.rdy_bpf = 1'b1;
    wait_until(cr + 8);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
